// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared core definitions: divider occupancy state encoding, stall control bundle,
// and the register-match rule used by both hazard detection and forwarding.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic mem_wb_bubble;
  } stall_ctl_t;

  // $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic hit(input reg_addr_t r, input logic used, input reg_addr_t addr);
    return used & (r == addr) & (r != '0);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-qualifier inputs and stall/bubble/divider controls of the interlock.
// master = pipeline datapath side, slave = hazard_stall_ctrl.
interface hazard_stall_ctrl_if;
  import cpu_pkg::*;

  logic      flush;
  reg_addr_t r1;
  reg_addr_t r2;
  logic      r1_used;
  logic      r2_used;
  logic      is_ID_EX_valid;
  logic      reg_write_EX;
  logic      is_load_EX;
  reg_addr_t reg_write_addr_EX;
  logic      is_div_EX;
  logic      is_EX_MEM_valid;
  logic      reg_write_MEM;
  logic      is_load_MEM;
  logic      is_mem_access_MEM;
  reg_addr_t reg_write_addr_MEM;
  logic      data_ok;

  logic      pc_stall;
  logic      if_id_stall;
  logic      id_ex_stall;
  logic      ex_mem_stall;
  logic      id_ex_bubble;
  logic      ex_mem_bubble;
  logic      mem_wb_bubble;
  logic      div_start;
  logic      div_cancel;
  logic      div_done;
  logic      load_use;

  modport master (
    output flush, r1, r2, r1_used, r2_used,
    output is_ID_EX_valid, reg_write_EX, is_load_EX, reg_write_addr_EX, is_div_EX,
    output is_EX_MEM_valid, reg_write_MEM, is_load_MEM, is_mem_access_MEM, reg_write_addr_MEM,
    output data_ok,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    input  id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
    input  div_start, div_cancel, div_done, load_use
  );

  modport slave (
    input  flush, r1, r2, r1_used, r2_used,
    input  is_ID_EX_valid, reg_write_EX, is_load_EX, reg_write_addr_EX, is_div_EX,
    input  is_EX_MEM_valid, reg_write_MEM, is_load_MEM, is_mem_access_MEM, reg_write_addr_MEM,
    input  data_ok,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    output id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
    output div_start, div_cancel, div_done, load_use
  );

endinterface

// File: rtl/hazard_stall_ctrl_div_occupancy.sv
// Tracks a divide in EX from launch to retirement; start/cancel are same-cycle
// pulses, busy/done decode the state register.
module div_occupancy
  import cpu_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic go_i,
  input  logic flush_i,
  input  logic mem_wait_i,
  output logic busy_o,
  output logic done_o,
  output logic start_o,
  output logic cancel_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  assign busy_o   = (state_q == BUSY);
  assign done_o   = (state_q == DONE);
  assign start_o  = (state_q == IDLE) & go_i & ~flush_i & ~mem_wait_i;
  assign cancel_o = (state_q != IDLE) & flush_i;

  // The divider free-runs in BUSY; only retirement out of DONE waits on memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_o) begin
            state_q <= BUSY;
            cnt_q   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (!mem_wait_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: resolves load-use, divider occupancy and data-memory wait
// into per-stage hold/bubble controls, highest-priority hazard wins.
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave hz
);

  logic       mem_wait;
  logic       lu_ex;
  logic       lu_mem;
  logic       load_use;
  logic       div_go;
  logic       div_busy;
  logic       div_done;
  logic       div_start;
  logic       div_cancel;
  logic       div_unretired;
  stall_ctl_t ctl;

  assign mem_wait = hz.is_EX_MEM_valid & hz.is_mem_access_MEM & ~hz.data_ok;

  assign lu_ex  = hz.is_ID_EX_valid & hz.reg_write_EX & hz.is_load_EX &
                  (hit(hz.r1, hz.r1_used, hz.reg_write_addr_EX) |
                   hit(hz.r2, hz.r2_used, hz.reg_write_addr_EX));
  // Once data_ok arrives the loaded value is forwarded, so the MEM leg clears.
  assign lu_mem = hz.is_EX_MEM_valid & hz.reg_write_MEM & hz.is_load_MEM & ~hz.data_ok &
                  (hit(hz.r1, hz.r1_used, hz.reg_write_addr_MEM) |
                   hit(hz.r2, hz.r2_used, hz.reg_write_addr_MEM));
  assign load_use = lu_ex | lu_mem;

  assign div_go = hz.is_ID_EX_valid & hz.is_div_EX;

  div_occupancy #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_occupancy (
    .clk        (clk),
    .reset      (reset),
    .go_i       (div_go),
    .flush_i    (hz.flush),
    .mem_wait_i (mem_wait),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .start_o    (div_start),
    .cancel_o   (div_cancel)
  );

  assign div_unretired = div_start | div_busy | (div_done & mem_wait);

  always_comb begin
    ctl = '0;
    if (hz.flush) begin
      ctl = '0;
    end else if (mem_wait) begin
      ctl.pc_stall      = 1'b1;
      ctl.if_id_stall   = 1'b1;
      ctl.id_ex_stall   = 1'b1;
      ctl.ex_mem_stall  = 1'b1;
      ctl.mem_wb_bubble = 1'b1;
    end else if (div_unretired) begin
      ctl.pc_stall      = 1'b1;
      ctl.if_id_stall   = 1'b1;
      ctl.id_ex_stall   = 1'b1;
      ctl.ex_mem_bubble = 1'b1;
    end else if (load_use) begin
      ctl.pc_stall      = 1'b1;
      ctl.if_id_stall   = 1'b1;
      ctl.id_ex_bubble  = 1'b1;
    end
  end

  assign hz.pc_stall      = ctl.pc_stall;
  assign hz.if_id_stall   = ctl.if_id_stall;
  assign hz.id_ex_stall   = ctl.id_ex_stall;
  assign hz.ex_mem_stall  = ctl.ex_mem_stall;
  assign hz.id_ex_bubble  = ctl.id_ex_bubble;
  assign hz.ex_mem_bubble = ctl.ex_mem_bubble;
  assign hz.mem_wb_bubble = ctl.mem_wb_bubble;
  assign hz.div_start     = div_start;
  assign hz.div_cancel    = div_cancel;
  assign hz.div_done      = div_done;
  assign hz.load_use      = load_use;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed hazard scenarios plus random traffic,
// checked every cycle against a cycle-count reference of the divider.
module tb_hazard_stall_ctrl;

  localparam int DIV_CYCLES = 4;
  localparam int CNT_W      = 3;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  // Cycles since divider launch; -1 when no divide is outstanding.
  int   age;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // [10]pc [9]if_id [8]id_ex [7]ex_mem stall, [6]id_ex [5]ex_mem [4]mem_wb bubble,
  // [3]div_start [2]div_cancel [1]div_done [0]load_use
  logic [10:0] outs;
  assign outs = {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
                 bus.id_ex_bubble, bus.ex_mem_bubble, bus.mem_wb_bubble,
                 bus.div_start, bus.div_cancel, bus.div_done, bus.load_use};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [4:0] r, input logic used, input logic [4:0] a);
    return used && (r == a) && (r != 5'd0);
  endfunction

  function automatic logic m_mem_wait();
    return bus.is_EX_MEM_valid && bus.is_mem_access_MEM && !bus.data_ok;
  endfunction

  function automatic logic m_launch();
    return (age < 0) && bus.is_ID_EX_valid && bus.is_div_EX && !bus.flush && !m_mem_wait();
  endfunction

  function automatic logic [10:0] model_out();
    logic mw, lu, idle, busy, done, launch;
    logic [10:0] e;
    mw     = m_mem_wait();
    lu     = (bus.is_ID_EX_valid && bus.reg_write_EX && bus.is_load_EX &&
              (m_hit(bus.r1, bus.r1_used, bus.reg_write_addr_EX) ||
               m_hit(bus.r2, bus.r2_used, bus.reg_write_addr_EX))) ||
             (bus.is_EX_MEM_valid && bus.reg_write_MEM && bus.is_load_MEM && !bus.data_ok &&
              (m_hit(bus.r1, bus.r1_used, bus.reg_write_addr_MEM) ||
               m_hit(bus.r2, bus.r2_used, bus.reg_write_addr_MEM)));
    idle   = (age < 0);
    busy   = (age >= 1) && (age <= DIV_CYCLES);
    done   = (age > DIV_CYCLES);
    launch = m_launch();
    e      = '0;
    e[3]   = launch;
    e[2]   = bus.flush && !idle;
    e[1]   = done;
    e[0]   = lu;
    if (bus.flush) begin
      e[10:4] = '0;
    end else if (mw) begin
      e[10:7] = 4'b1111;
      e[4]    = 1'b1;
    end else if (launch || busy || (done && mw)) begin
      e[10:8] = 3'b111;
      e[5]    = 1'b1;
    end else if (lu) begin
      e[10:9] = 2'b11;
      e[6]    = 1'b1;
    end
    return e;
  endfunction

  function automatic int next_age();
    if (bus.flush) return -1;
    if (age < 0) return m_launch() ? 1 : -1;
    if (age <= DIV_CYCLES) return age + 1;
    return m_mem_wait() ? age : -1;
  endfunction

  task automatic clear_inputs();
    bus.flush = 0; bus.r1 = 0; bus.r2 = 0; bus.r1_used = 0; bus.r2_used = 0;
    bus.is_ID_EX_valid = 0; bus.reg_write_EX = 0; bus.is_load_EX = 0;
    bus.reg_write_addr_EX = 0; bus.is_div_EX = 0;
    bus.is_EX_MEM_valid = 0; bus.reg_write_MEM = 0; bus.is_load_MEM = 0;
    bus.is_mem_access_MEM = 0; bus.reg_write_addr_MEM = 0; bus.data_ok = 0;
  endtask

  // Called at posedge+1; samples at the falling edge.
  task automatic settle(input string tag);
    #4;
    check_eq(tag, 32'(outs), 32'(model_out()));
  endtask

  task automatic tick();
    @(posedge clk);
    age = next_age();
    #1;
  endtask

  task automatic set_div();
    bus.is_ID_EX_valid = 1; bus.is_div_EX = 1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    age     = -1;
    reset   = 1'b1;
    clear_inputs();

    #3;
    check_eq("reset_outs", 32'(outs), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Load in EX writes $5, ID reads $5.
    bus.is_ID_EX_valid = 1; bus.reg_write_EX = 1; bus.is_load_EX = 1;
    bus.reg_write_addr_EX = 5; bus.r1 = 5; bus.r1_used = 1;
    settle("lu_ex");
    check_eq("lu_ex_bits", 32'({outs[10:9], outs[6], outs[0]}), 32'hF);
    tick();
    clear_inputs();
    bus.is_EX_MEM_valid = 1; bus.reg_write_MEM = 1; bus.is_load_MEM = 1;
    bus.is_mem_access_MEM = 1; bus.reg_write_addr_MEM = 5; bus.data_ok = 1;
    bus.r1 = 5; bus.r1_used = 1;
    settle("lu_ex_next");
    check_eq("lu_ex_next_clear", 32'(outs), 32'd0);
    tick();

    // $0 never interlocks.
    clear_inputs();
    bus.is_ID_EX_valid = 1; bus.reg_write_EX = 1; bus.is_load_EX = 1;
    bus.reg_write_addr_EX = 0; bus.r1 = 0; bus.r1_used = 1;
    settle("lu_r0");
    check_eq("lu_r0_none", 32'(outs), 32'd0);
    tick();

    // Plain divide: stall T..T+4, done at T+5.
    clear_inputs();
    set_div();
    settle("div_T");
    check_eq("div_start_T", 32'(outs[3]), 32'd1);
    tick();
    for (int k = 1; k <= DIV_CYCLES; k++) begin
      settle("div_busy");
      check_eq("div_busy_stall", 32'({outs[8], outs[5], outs[1]}), 32'b110);
      tick();
    end
    settle("div_done");
    check_eq("div_done_nostall", 32'(outs), 32'b000_0000_0010);
    tick();
    clear_inputs();
    settle("div_after");
    check_eq("div_after_idle", 32'(outs[1]), 32'd0);
    tick();

    // mem_wait for 3 cycles while DONE.
    set_div();
    for (int k = 0; k <= DIV_CYCLES; k++) begin
      settle("div2_busy");
      tick();
    end
    bus.is_EX_MEM_valid = 1; bus.is_mem_access_MEM = 1; bus.data_ok = 0;
    for (int k = 0; k < 3; k++) begin
      settle("done_wait");
      check_eq("done_wait_held", 32'({outs[1], outs[4], outs[7]}), 32'b111);
      tick();
    end
    bus.data_ok = 1;
    settle("done_retire");
    check_eq("done_retire_bits", 32'(outs), 32'b000_0000_0010);
    tick();
    clear_inputs();
    settle("done_idle");
    check_eq("done_idle_bits", 32'(outs), 32'd0);
    tick();

    // flush mid-BUSY.
    set_div();
    for (int k = 0; k < 3; k++) begin
      settle("fl_busy");
      tick();
    end
    bus.flush = 1;
    settle("fl_cancel");
    check_eq("fl_cancel_bits", 32'(outs), 32'b000_0000_0100);
    tick();
    clear_inputs();
    settle("fl_after");
    check_eq("fl_after_bits", 32'(outs), 32'd0);
    tick();

    // flush in the launch cycle: no start.
    set_div();
    bus.flush = 1;
    settle("fl_launch");
    check_eq("fl_launch_nostart", 32'(outs[3]), 32'd0);
    tick();
    clear_inputs();
    settle("fl_launch_after");
    check_eq("fl_launch_idle", 32'(outs), 32'd0);
    tick();

    // Load in MEM waiting on data_ok, ID reads its dest.
    bus.is_EX_MEM_valid = 1; bus.reg_write_MEM = 1; bus.is_load_MEM = 1;
    bus.is_mem_access_MEM = 1; bus.reg_write_addr_MEM = 7; bus.data_ok = 0;
    bus.r2 = 7; bus.r2_used = 1;
    for (int k = 0; k < 2; k++) begin
      settle("lu_mem_wait");
      check_eq("lu_mem_prio", 32'({outs[7], outs[6], outs[0]}), 32'b101);
      tick();
    end
    bus.data_ok = 1;
    settle("lu_mem_ok");
    check_eq("lu_mem_ok_bits", 32'(outs), 32'd0);
    tick();

    // Reset asserted mid-BUSY.
    clear_inputs();
    set_div();
    for (int k = 0; k < 3; k++) begin
      settle("rst_busy");
      tick();
    end
    clear_inputs();
    reset = 1'b1;
    #2;
    check_eq("rst_mid_busy", 32'(outs), 32'd0);
    age = -1;
    @(posedge clk); #1;
    reset = 1'b0;
    settle("rst_after");
    tick();

    // Random traffic on a small register set to provoke frequent matches.
    for (int c = 0; c < 600; c++) begin
      bus.flush              = ($urandom_range(0, 15) == 0);
      bus.r1                 = 5'($urandom_range(0, 3));
      bus.r2                 = 5'($urandom_range(0, 3));
      bus.r1_used            = 1'($urandom);
      bus.r2_used            = 1'($urandom);
      bus.is_ID_EX_valid     = ($urandom_range(0, 3) != 0);
      bus.reg_write_EX       = 1'($urandom);
      bus.is_load_EX         = 1'($urandom);
      bus.reg_write_addr_EX  = 5'($urandom_range(0, 3));
      bus.is_div_EX          = ($urandom_range(0, 3) == 0);
      bus.is_EX_MEM_valid    = 1'($urandom);
      bus.reg_write_MEM      = 1'($urandom);
      bus.is_load_MEM        = 1'($urandom);
      bus.is_mem_access_MEM  = ($urandom_range(0, 2) == 0);
      bus.reg_write_addr_MEM = 5'($urandom_range(0, 3));
      bus.data_ok            = ($urandom_range(0, 2) != 0);
      settle("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
